// File: rtl/barrel_shifter_pipe_if.sv
// Operand and result handshake bundle for the pipelined barrel shifter.
// The master side is the operand source and result consumer. The slave side is the shifter.
interface barrel_shifter_pipe_if #(
   parameter int WIDTH = 8
);
   localparam int SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [1:0]       in_mode;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;

   modport master (
      output in_valid, in_data, in_shamt, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_carry, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_carry, out_zero
   );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Two-stage pipelined barrel shifter with LSL/LSR/ASR/ROL modes, carry-out and zero flag.
// Low shift layers sit before stage 1 and high layers sit before stage 2. Valid/ready is used on both sides.
module barrel_shifter_pipe #(
   parameter int WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   barrel_shifter_pipe_if.slave bus
);
   localparam int SHW   = $clog2(WIDTH);
   localparam int SPLIT = SHW / 2;
   localparam int SHW2  = SHW - SPLIT;

   typedef enum logic [1:0] {
      MODE_LSL = 2'b00,
      MODE_LSR = 2'b01,
      MODE_ASR = 2'b10,
      MODE_ROL = 2'b11
   } mode_t;

   // One mux layer shifts by 2^k. The carry becomes the last bit this layer pushed out.
   // Layers compose, so the final carry is the last bit pushed out by the whole shift.
   function automatic logic [WIDTH:0] shift_layer(input logic [WIDTH-1:0] d, input logic c,
                                                  input mode_t mode, input int k);
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] hi_out;
      logic [WIDTH-1:0] lo_out;
      logic             nc;
      int               amt;
      amt    = 1 << k;
      hi_out = d >> (WIDTH - amt);
      lo_out = d >> (amt - 1);
      r      = d;
      nc     = c;
      case (mode)
         MODE_LSL: begin r = d << amt;                          nc = hi_out[0]; end
         MODE_LSR: begin r = d >> amt;                          nc = lo_out[0]; end
         MODE_ASR: begin r = $signed(d) >>> amt;                nc = lo_out[0]; end
         MODE_ROL: begin r = (d << amt) | (d >> (WIDTH - amt)); nc = r[0];      end
         default:  ;
      endcase
      return {nc, r};
   endfunction

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic             s1_carry;
   logic [SHW2-1:0]  s1_shamt;
   mode_t            s1_mode;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_data;
   logic             s2_carry;
   logic             s2_zero;

   logic             s1_load;
   logic             s2_load;
   mode_t            in_mode_e;
   logic [WIDTH:0]   s1_next;
   logic [WIDTH:0]   s2_next;
   logic [SHW-1:0]   lo_bits;
   logic [SHW2-1:0]  hi_bits;

   assign in_mode_e = mode_t'(bus.in_mode);
   assign s2_load   = !s2_valid || bus.out_ready;
   assign s1_load   = !s1_valid || s2_load;

   always_comb begin
      s1_next = {1'b0, bus.in_data};
      lo_bits = '0;
      for (int k = 0; k < SPLIT; k++) begin
         lo_bits = bus.in_shamt >> k;
         if (lo_bits[0]) begin
            s1_next = shift_layer(s1_next[WIDTH-1:0], s1_next[WIDTH], in_mode_e, k);
         end
      end
   end

   always_comb begin
      s2_next = {s1_carry, s1_data};
      hi_bits = '0;
      for (int j = 0; j < SHW2; j++) begin
         hi_bits = s1_shamt >> j;
         if (hi_bits[0]) begin
            s2_next = shift_layer(s2_next[WIDTH-1:0], s2_next[WIDTH], s1_mode, j + SPLIT);
         end
      end
   end

   // The result registers only change when a new beat moves in, so they hold while stalled or empty.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_carry <= 1'b0;
         s1_shamt <= '0;
         s1_mode  <= MODE_LSL;
         s2_valid <= 1'b0;
         s2_data  <= '0;
         s2_carry <= 1'b0;
         s2_zero  <= 1'b0;
      end else begin
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data  <= s2_next[WIDTH-1:0];
               s2_carry <= s2_next[WIDTH];
               s2_zero  <= (s2_next[WIDTH-1:0] == '0);
            end
         end
         if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_data  <= s1_next[WIDTH-1:0];
               s1_carry <= s1_next[WIDTH];
               s1_shamt <= bus.in_shamt[SHW-1:SPLIT];
               s1_mode  <= in_mode_e;
            end
         end
      end
   end

   assign bus.in_ready  = s1_load;
   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_carry = s2_carry;
   assign bus.out_zero  = s2_zero;
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe at WIDTH=8.
// Stimulus pushes expected results into a queue, and an independent monitor pops them and compares.
module tb_barrel_shifter_pipe;
   localparam int W = 8;
   localparam logic [1:0] LSL = 2'b00;
   localparam logic [1:0] LSR = 2'b01;
   localparam logic [1:0] ASR = 2'b10;
   localparam logic [1:0] ROL = 2'b11;

   typedef struct {
      logic [W-1:0] data;
      logic         carry;
      logic         zero;
      int           acc_cyc;
      bit           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   pop_log[$];
   bit   stim_done;

   barrel_shifter_pipe_if #(.WIDTH(W)) bus ();

   barrel_shifter_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: shift one bit at a time and remember the last bit that fell off.
   function automatic logic [W:0] refShift(input logic [W-1:0] d, input int s, input logic [1:0] m);
      logic [W-1:0] r;
      logic         c;
      r = d;
      c = 1'b0;
      for (int i = 0; i < s; i++) begin
         case (m)
            LSL:     begin c = r[W-1]; r = {r[W-2:0], 1'b0};   end
            LSR:     begin c = r[0];   r = {1'b0, r[W-1:1]};   end
            ASR:     begin c = r[0];   r = {r[W-1], r[W-1:1]}; end
            default: begin r = {r[W-2:0], r[W-1]}; c = r[0];   end
         endcase
      end
      return {c, r};
   endfunction

   task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                                input logic [7:0] exp_d, input logic exp_c, input bit push, input bit lat);
      int   budget;
      exp_t e;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_shamt = s;
      bus.in_mode  = m;
      #1;
      budget = 200;
      while (!bus.in_ready && budget > 0) begin
         @(negedge clk);
         #1;
         budget--;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout actual=in_ready_low expected=accept (cycle %0d)", cyc);
         bus.in_valid = 1'b0;
      end else if (push) begin
         e.data    = exp_d;
         e.carry   = exp_c;
         e.zero    = (exp_d == 8'h00);
         e.acc_cyc = cyc;
         e.lat     = lat;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int budget;
      budget = 500;
      while (sb.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      repeat (3) @(negedge clk);
      checkOutput(name, sb.size(), 0);
   endtask

   // Monitor: a transfer happens at the next posedge when valid && ready is seen mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            pop_log.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output actual=%02h expected=none (cycle %0d)", bus.out_data, cyc);
            end else begin
               e = sb.pop_front();
               checkOutput("out_data", bus.out_data, e.data);
               checkOutput("out_carry", bus.out_carry, e.carry);
               checkOutput("out_zero", bus.out_zero, e.zero);
               if (e.lat) checkOutput("latency", cyc - e.acc_cyc, 2);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] d;
      logic [2:0] s;
      logic [1:0] m;
      logic [8:0] r;
      int         t0;
      int         gap;
      bit         ok;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_shamt  = '0;
      bus.in_mode   = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset_out_valid", bus.out_valid, 0);
      checkOutput("reset_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_out_data", bus.out_data, 8'h00);
      checkOutput("reset_out_carry", bus.out_carry, 0);
      checkOutput("reset_out_zero", bus.out_zero, 0);

      $display("[TB] modes on 0x96 by 3");
      applyStimulus(8'h96, 3'd3, LSL, 8'hB0, 1'b0, 1, 1);
      applyStimulus(8'h96, 3'd3, LSR, 8'h12, 1'b1, 1, 1);
      applyStimulus(8'h96, 3'd3, ASR, 8'hF2, 1'b1, 1, 1);
      applyStimulus(8'h96, 3'd3, ROL, 8'hB4, 1'b0, 1, 1);
      idle();
      waitDrain("modes_drain");

      $display("[TB] edge cases");
      applyStimulus(8'h40, 3'd7, LSR, 8'h00, 1'b1, 1, 0);
      applyStimulus(8'hA5, 3'd0, LSL, 8'hA5, 1'b0, 1, 0);
      applyStimulus(8'hA5, 3'd0, LSR, 8'hA5, 1'b0, 1, 0);
      applyStimulus(8'hA5, 3'd0, ASR, 8'hA5, 1'b0, 1, 0);
      applyStimulus(8'hA5, 3'd0, ROL, 8'hA5, 1'b0, 1, 0);
      applyStimulus(8'h80, 3'd7, ASR, 8'hFF, 1'b0, 1, 0);
      applyStimulus(8'h81, 3'd1, LSL, 8'h02, 1'b1, 1, 0);
      applyStimulus(8'h81, 3'd7, ROL, 8'hC0, 1'b0, 1, 0);
      idle();
      waitDrain("edges_drain");

      $display("[TB] streaming");
      pop_log.delete();
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         s = 3'($urandom_range(0, 7));
         m = 2'($urandom_range(0, 3));
         r = refShift(d, int'(s), m);
         applyStimulus(d, s, m, r[7:0], r[8], 1, 1);
      end
      idle();
      waitDrain("stream_drain");
      checkOutput("stream_count", pop_log.size(), 16);
      ok = (pop_log.size() == 16);
      for (int i = 1; i < pop_log.size(); i++) begin
         if (pop_log[i] != pop_log[i-1] + 1) ok = 1'b0;
      end
      checkOutput("stream_back_to_back", ok, 1);

      $display("[TB] backpressure");
      @(negedge clk);
      bus.out_ready = 1'b0;
      applyStimulus(8'h96, 3'd3, LSL, 8'hB0, 1'b0, 1, 0);
      applyStimulus(8'h96, 3'd3, LSR, 8'h12, 1'b1, 1, 0);
      @(negedge clk);
      bus.in_data  = 8'h96;
      bus.in_shamt = 3'd3;
      bus.in_mode  = ASR;
      #1;
      checkOutput("bp_in_ready_low", bus.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("bp_out_valid_held", bus.out_valid, 1);
         checkOutput("bp_out_data_frozen", bus.out_data, 8'hB0);
         checkOutput("bp_in_ready_held_low", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      checkOutput("bp_accept_on_release", bus.in_ready, 1);
      if (bus.in_ready) begin
         sb.push_back('{data: 8'hF2, carry: 1'b1, zero: 1'b0, acc_cyc: cyc, lat: 1'b0});
      end
      idle();
      waitDrain("bp_drain");

      $display("[TB] random handshake");
      stim_done = 1'b0;
      t0 = cyc;
      fork
         begin
            while (!stim_done) begin
               @(negedge clk);
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
         begin
            while (cyc < t0 + 2000) begin
               d = 8'($urandom);
               s = 3'($urandom_range(0, 7));
               m = 2'($urandom_range(0, 3));
               r = refShift(d, int'(s), m);
               applyStimulus(d, s, m, r[7:0], r[8], 1, 0);
               gap = $urandom_range(0, 2);
               repeat (gap) idle();
            end
            idle();
            stim_done = 1'b1;
         end
      join
      waitDrain("random_drain");

      $display("[TB] reset with beats in flight");
      @(negedge clk);
      bus.out_ready = 1'b0;
      applyStimulus(8'h11, 3'd1, LSL, 8'h22, 1'b0, 0, 0);
      applyStimulus(8'h33, 3'd2, ROL, 8'hCC, 1'b0, 0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_in_ready", bus.in_ready, 1);
      checkOutput("rst_out_data", bus.out_data, 8'h00);
      checkOutput("rst_out_carry", bus.out_carry, 0);
      checkOutput("rst_out_zero", bus.out_zero, 0);
      pop_log.delete();
      @(negedge clk);
      bus.out_ready = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("rst_no_stale_output", pop_log.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
